// File: rtl/csel_adder_pipe.sv
// Two-stage carry-select adder: stage 1 registers per-block candidate sums, stage 2 selects and registers.
// Latency 2 edges, one add per cycle; in_ready drops only when both stages are full and out_ready is low.
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NB = WIDTH / BLK;
  localparam logic [BLK:0] ONE = (BLK+1)'(1);

  typedef struct packed {
    logic [BLK:0]           blk0;
    logic [NB-1:1][BLK:0]   s0;
    logic [NB-1:1][BLK:0]   s1;
    logic                   msb_a;
    logic                   msb_b;
  } stage1_t;

  stage1_t          stg_n;
  stage1_t          stg;
  logic             s1_valid;
  logic             s1_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [NB-1:0]    c;
  logic [WIDTH-1:0] sum_n;
  logic             ovf_n;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Upper blocks precompute both carry-in cases; block 0 already knows its carry.
  always_comb begin
    stg_n = '0;
    stg_n.blk0 = {1'b0, A[BLK-1:0]} + {1'b0, B[BLK-1:0]} + {{BLK{1'b0}}, Cin};
    for (int k = 1; k < NB; k++) begin
      stg_n.s0[k] = {1'b0, A[k*BLK +: BLK]} + {1'b0, B[k*BLK +: BLK]};
      stg_n.s1[k] = {1'b0, A[k*BLK +: BLK]} + {1'b0, B[k*BLK +: BLK]} + ONE;
    end
    stg_n.msb_a = A[WIDTH-1];
    stg_n.msb_b = B[WIDTH-1];
  end

  always_comb begin
    sum_n          = '0;
    c              = '0;
    c[0]           = stg.blk0[BLK];
    sum_n[BLK-1:0] = stg.blk0[BLK-1:0];
    for (int k = 1; k < NB; k++) begin
      sum_n[k*BLK +: BLK] = c[k-1] ? stg.s1[k][BLK-1:0] : stg.s0[k][BLK-1:0];
      c[k]                = c[k-1] ? stg.s1[k][BLK]     : stg.s0[k][BLK];
    end
    ovf_n = (stg.msb_a == stg.msb_b) && (sum_n[WIDTH-1] != stg.msb_a);
  end

  // Candidate registers carry no reset: s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_xfer) stg <= stg_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      if (in_xfer)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv) begin
        out_valid <= 1'b1;
        Sum       <= sum_n;
        Cout      <= c[NB-1];
        Ovf       <= ovf_n;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed bench for csel_adder_pipe: corner adds, streaming, backpressure and mid-flight reset.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Cout;
  logic        Ovf;

  int n_chk  = 0;
  int n_pass = 0;

  csel_adder_pipe #(.WIDTH(32), .BLK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic ci);
    in_valid = 1'b1;
    A = a;
    B = b;
    Cin = ci;
  endtask

  // Single add through an empty pipe: result visible after the second edge, then drained.
  task automatic do_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    out_ready = 1'b1;
    offer(a, b, ci);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(Sum), 64'(es));
    check({tag, "_cout"}, 64'(Cout), 64'(ec));
    check({tag, "_ovf"}, 64'(Ovf), 64'(eo));
    step();
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] va [16];
  logic [31:0] vb [16];
  logic        vc [16];
  logic [32:0] ref_full;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(Sum), 64'd0);
    check("rst_cout", 64'(Cout), 64'd0);
    check("rst_ovf", 64'(Ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    do_add("chain",   32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    do_add("blk0sel", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    do_add("blk2sel", 32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0, 1'b0);
    do_add("midblk",  32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0, 1'b0);
    do_add("ovfpos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    do_add("ovfneg",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    do_add("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_add("mixed",   32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);

    // Back-to-back stream: vector j accepted at edge j, its result visible after edge j+1.
    for (int i = 0; i < 16; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(1, 0));
    end
    out_ready = 1'b1;
    offer(va[0], vb[0], vc[0]);
    for (int j = 0; j <= 16; j++) begin
      check($sformatf("stream_rdy%0d", j), 64'(in_ready), 64'd1);
      step();
      if (j + 1 < 16) offer(va[j+1], vb[j+1], vc[j+1]);
      else in_valid = 1'b0;
      check($sformatf("stream_vld%0d", j), 64'(out_valid), 64'(j >= 1));
      if (j >= 1) begin
        ref_full = {1'b0, va[j-1]} + {1'b0, vb[j-1]} + 33'(vc[j-1]);
        check($sformatf("stream_sum%0d", j-1), 64'(Sum), 64'(ref_full[31:0]));
        check($sformatf("stream_cout%0d", j-1), 64'(Cout), 64'(ref_full[32]));
        check($sformatf("stream_ovf%0d", j-1), 64'(Ovf),
              64'((va[j-1][31] == vb[j-1][31]) && (ref_full[31] != va[j-1][31])));
      end
    end
    step();
    check("stream_end", 64'(out_valid), 64'd0);

    // Backpressure: two entries fill the pipe, the third waits until out_ready returns.
    out_ready = 1'b0;
    offer(32'h00000010, 32'h00000020, 1'b0);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    step();
    offer(32'h0000FFFF, 32'h00000001, 1'b0);
    check("bp_rdy2", 64'(in_ready), 64'd1);
    step();
    offer(32'hFFFFFFFE, 32'h00000003, 1'b0);
    check("bp_full_rdy", 64'(in_ready), 64'd0);
    check("bp_vld", 64'(out_valid), 64'd1);
    check("bp_sum1", 64'(Sum), 64'h00000030);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_rdy%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_hold_sum%0d", i), 64'(Sum), 64'h00000030);
      check($sformatf("bp_hold_vld%0d", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_sum2_vld", 64'(out_valid), 64'd1);
    check("bp_sum2", 64'(Sum), 64'h00010000);
    check("bp_cout2", 64'(Cout), 64'd0);
    step();
    check("bp_sum3_vld", 64'(out_valid), 64'd1);
    check("bp_sum3", 64'(Sum), 64'h00000001);
    check("bp_cout3", 64'(Cout), 64'd1);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Reset with both stages occupied: nothing stale may surface afterwards.
    out_ready = 1'b0;
    offer(32'h00000005, 32'h00000006, 1'b0);
    step();
    offer(32'h00000007, 32'h00000008, 1'b0);
    step();
    in_valid = 1'b0;
    check("mf_full_rdy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mf_vld", 64'(out_valid), 64'd0);
    check("mf_sum", 64'(Sum), 64'd0);
    check("mf_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mf_nostale%0d", i), 64'(out_valid), 64'd0);
    end
    do_add("post_rst", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Pipelined carry-select adder, WIDTH bits, split into BLK-bit blocks.
- Stage 1 registers the per-block candidate sums: carry-in 0 and carry-in 1 for the upper blocks, and the true sum for block 0.
- Stage 2 resolves the block carry chain and selects one candidate per block, then registers the result.
- Valid/ready handshake on both sides. Full throughput of one add per cycle when out_ready is high.

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of BLK.
- BLK, 8, block width; NB = WIDTH/BLK blocks, NB >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A, B, Cin valid
- in_ready  output  1  block can accept an operand set this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry into bit 0
- out_valid  output  1  Sum, Cout, Ovf valid
- out_ready  input  1  consumer accepts the result this cycle
- Sum  output  WIDTH  A+B+Cin, modulo 2^WIDTH
- Cout  output  1  carry out of the MSB
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset (rst=1 at a clk edge): s1_valid=0, out_valid=0, Sum=0, Cout=0, Ovf=0. Candidate registers are don't-care. Reset overrides any handshake in the same cycle.
- Input transfer: in_valid && in_ready at an edge. Output transfer: out_valid && out_ready at an edge.
- Stage 1 register, loaded on input transfer:
  - blk0 = A[BLK-1:0] + B[BLK-1:0] + Cin, BLK+1 bits.
  - For k = 1..NB-1: s0_k = A_k + B_k and s1_k = A_k + B_k + 1, both BLK+1 bits.
  - Capture msbA = A[WIDTH-1] and msbB = B[WIDTH-1].
- Stage 2, combinational from stage 1:
  - c_0 = blk0[BLK].
  - For k >= 1: c_k = c_{k-1} ? s1_k[BLK] : s0_k[BLK].
  - Sum block k = c_{k-1} ? s1_k[BLK-1:0] : s0_k[BLK-1:0].
  - Cout = c_{NB-1}.
  - Ovf = (msbA == msbB) && (Sum[WIDTH-1] != msbA).
- Output register: loads Sum, Cout, Ovf and sets out_valid when s1_valid && (!out_valid || out_ready).
- Stall: while out_valid && !out_ready, Sum, Cout and Ovf are held bit-stable.
- s1 advance: s1_adv = s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || s1_adv. This is combinational from registered state and out_ready only, never from in_valid.
- s1_valid next:
  - 1 if an input transfer occurs;
  - else 0 if s1_adv;
  - else hold.
- out_valid next:
  - 1 if s1_adv;
  - else 0 if an output transfer occurs;
  - else hold.
- Latency: an operand accepted at edge N has out_valid=1 after edge N+1, provided the output stage is free.
- Simultaneous events: input transfer and s1_adv in the same cycle are legal; the stage 1 register is overwritten with the new operands.
- Capacity: 2 entries (stage 1 + output). When both are full and out_ready=0, in_ready=0.
- Ordering: strictly FIFO; no result is dropped or duplicated.
- Input hold: A, B and Cin are don't-care when in_valid=0. The block does not depend on inputs being held after a transfer.
- Arithmetic: unsigned modulo 2^WIDTH. Block carry-out candidates are exactly BLK+1 bits; no wider intermediates.
- Reset mid-operation: any in-flight operands are discarded. in_ready=1 on the cycle after reset deasserts.

Test Plan:
- Basic carry chain: A=FFFFFFFF, B=00000000, Cin=1, out_ready=1 -> two cycles later Sum=00000000, Cout=1, Ovf=0.
- Block-boundary select: A=000000FF, B=00000001, Cin=0 -> Sum=00000100, Cout=0. Also A=00FFFFFF, B=0, Cin=1 -> Sum=01000000.
- Signed overflow: A=7FFFFFFF + B=00000001 -> Ovf=1, Cout=0. A=80000000 + B=80000000 -> Sum=00000000, Cout=1, Ovf=1.
- Back-to-back throughput: 16 consecutive random operand sets, out_ready=1 -> 16 results in order, one per cycle, each matching the reference model.
- Backpressure: hold out_ready=0, offer 3 operand sets -> only 2 accepted, in_ready=0 from the cycle the second set is accepted. Sum held stable. Release out_ready -> the 3rd set is accepted, and all 3 results emerge in order.
- Reset mid-flight: 2 entries in flight, assert rst for one cycle -> out_valid=0, Sum=0 the next cycle, no stale result ever appears. A new add 00000001+00000001 yields Sum=00000002.
